// File: rtl/ram_sdp_clr.sv
// Single-clock simple-dual-port RAM with byte enables, registered read and a clear FSM.
// Optional per-lane even parity storage and checking is enabled by defining RAM_PARITY_EN.
module ram_sdp_clr #(
    parameter int D_WIDTH  = 16,
    parameter int A_WIDTH  = 4,
    parameter int DEPTH    = 16,
    parameter int RDW_MODE = 0,
    parameter int BE_WIDTH = D_WIDTH / 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_req,
    output logic                init_busy,
    input  logic                wr_en,
    input  logic [A_WIDTH-1:0]  wr_addr,
    input  logic [BE_WIDTH-1:0] wr_be,
    input  logic [D_WIDTH-1:0]  wr_data,
    input  logic                rd_en,
    input  logic [A_WIDTH-1:0]  rd_addr,
    output logic [D_WIDTH-1:0]  rd_data,
    output logic                rd_valid
`ifdef RAM_PARITY_EN
    ,
    input  logic                wr_par_inv,
    output logic                rd_perr
`endif
);

    typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

    localparam logic [A_WIDTH:0]   DEPTH_W   = (A_WIDTH + 1)'(DEPTH);
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);
    localparam logic               RDW_NEW   = (RDW_MODE == 32'sd1);

    function automatic logic [BE_WIDTH-1:0] lane_parity(input logic [D_WIDTH-1:0] data);
        logic [BE_WIDTH-1:0] par;
        par = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            par[i] = ^data[8*i +: 8];
        end
        return par;
    endfunction

    state_t               state_q, state_d;
    logic [A_WIDTH-1:0]   cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [D_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [D_WIDTH-1:0]   mem_q [DEPTH];

    logic                 idle_s;
    logic                 wr_in_range_s;
    logic                 rd_in_range_s;
    logic                 bypass_s;
    logic                 mem_we_s;
    logic [A_WIDTH-1:0]   mem_addr_s;
    logic [BE_WIDTH-1:0]  mem_be_s;
    logic [D_WIDTH-1:0]   mem_wdata_s;
    logic [D_WIDTH-1:0]   rd_old_s;
    logic [D_WIDTH-1:0]   rd_word_s;

`ifdef RAM_PARITY_EN
    logic [BE_WIDTH-1:0]  par_q [DEPTH];
    logic [BE_WIDTH-1:0]  par_wdata_s;
    logic [BE_WIDTH-1:0]  par_new_s;
    logic [BE_WIDTH-1:0]  rd_par_old_s;
    logic [BE_WIDTH-1:0]  rd_par_s;
    logic                 rd_perr_q, rd_perr_d;
`endif

    assign idle_s        = (state_q == ST_IDLE);
    assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_W);
    assign bypass_s      = RDW_NEW && idle_s && wr_en && wr_in_range_s && (wr_addr == rd_addr);

    // Clear sequencer: walks cnt over every word, then parks in IDLE until init_req.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q + A_WIDTH'(1'b1);
                end
            end
            ST_IDLE: begin
                if (init_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Write-port mux: the clear sequence owns the array while it runs.
    always_comb begin
        mem_addr_s  = wr_addr;
        mem_be_s    = wr_be;
        mem_wdata_s = wr_data;
        if (!idle_s) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = cnt_q;
            mem_be_s    = '1;
            mem_wdata_s = '0;
        end else begin
            mem_we_s    = wr_en && wr_in_range_s;
        end
    end

    // Byte-lane array write; the array has no reset, the clear sequence rewrites it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (mem_we_s && mem_be_s[i]) begin
                mem_q[mem_addr_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
            end
        end
    end

    // Read word with optional same-address bypass of the lanes being written.
    always_comb begin
        rd_old_s  = rd_in_range_s ? mem_q[rd_addr] : '0;
        rd_word_s = rd_old_s;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (bypass_s && wr_be[i]) begin
                rd_word_s[8*i +: 8] = wr_data[8*i +: 8];
            end else begin
                rd_word_s[8*i +: 8] = rd_old_s[8*i +: 8];
            end
        end
        rd_valid_d = rd_en && idle_s;
        rd_data_d  = (rd_en && idle_s) ? rd_word_s : rd_data_q;
    end

`ifdef RAM_PARITY_EN
    assign par_new_s   = lane_parity(wr_data) ^ {BE_WIDTH{wr_par_inv}};
    assign par_wdata_s = idle_s ? par_new_s : '0;

    // Parity array write, lane-aligned with the data write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (mem_we_s && mem_be_s[i]) begin
                par_q[mem_addr_s][i] <= par_wdata_s[i];
            end
        end
    end

    // Parity check on the word being returned, bypassed lanes use the parity being stored.
    always_comb begin
        rd_par_old_s = rd_in_range_s ? par_q[rd_addr] : '0;
        rd_par_s     = rd_par_old_s;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (bypass_s && wr_be[i]) begin
                rd_par_s[i] = par_new_s[i];
            end else begin
                rd_par_s[i] = rd_par_old_s[i];
            end
        end
        rd_perr_d = (rd_en && idle_s) ? |(lane_parity(rd_word_s) ^ rd_par_s) : rd_perr_q;
    end

    // Parity error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_perr_q <= 1'b0;
        end else begin
            rd_perr_q <= rd_perr_d;
        end
    end

    assign rd_perr = rd_perr_q;
`endif

    // Control and read-output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign init_busy = busy_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Scoreboard bench for ram_sdp_clr: two DEPTH=16 instances (old/new read-during-write)
// sharing stimulus, plus a DEPTH=12 instance for out-of-range addressing.
module tb_ram_sdp_clr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        init_req = 1'b0, init_req_c = 1'b0;
    logic        wr_en = 1'b0, rd_en = 1'b0, wr_en_c = 1'b0, rd_en_c = 1'b0;
    logic [3:0]  wr_addr = 4'd0, rd_addr = 4'd0;
    logic [1:0]  wr_be = 2'b00;
    logic [15:0] wr_data = 16'h0000;
    logic        busy_a, busy_b, busy_c;
    logic        rvalid_a, rvalid_b, rvalid_c;
    logic [15:0] rdata_a, rdata_b, rdata_c;
`ifdef RAM_PARITY_EN
    logic        wr_par_inv = 1'b0;
    logic        perr_a, perr_b, perr_c;
`endif

    typedef struct packed {
        int          due;
        logic [15:0] da;
        logic [15:0] db;
        logic        pa;
        logic        pb;
    } exp_t;

    exp_t        q_ab[$];
    exp_t        q_c[$];
    exp_t        mon_e;
    bit          hit_ab, hit_c;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_on = 1'b0;
    logic [15:0] last_a = 16'h0, last_b = 16'h0, last_c = 16'h0;
    logic        lp_a = 1'b0, lp_b = 1'b0, lp_c = 1'b0;
    logic [15:0] m [16];
    logic [1:0]  pm [16];
    logic [15:0] mc [12];
    logic [1:0]  pmc [12];
    int          clr_ab = 0;

    always #5 clk = ~clk;

    ram_sdp_clr #(.D_WIDTH(16), .A_WIDTH(4), .DEPTH(16), .RDW_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdata_a), .rd_valid(rvalid_a)
`ifdef RAM_PARITY_EN
        , .wr_par_inv(wr_par_inv), .rd_perr(perr_a)
`endif
    );

    ram_sdp_clr #(.D_WIDTH(16), .A_WIDTH(4), .DEPTH(16), .RDW_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdata_b), .rd_valid(rvalid_b)
`ifdef RAM_PARITY_EN
        , .wr_par_inv(wr_par_inv), .rd_perr(perr_b)
`endif
    );

    ram_sdp_clr #(.D_WIDTH(16), .A_WIDTH(4), .DEPTH(12), .RDW_MODE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .init_req(init_req_c), .init_busy(busy_c),
        .wr_en(wr_en_c), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en_c), .rd_addr(rd_addr), .rd_data(rdata_c), .rd_valid(rvalid_c)
`ifdef RAM_PARITY_EN
        , .wr_par_inv(wr_par_inv), .rd_perr(perr_c)
`endif
    );

    function automatic logic [1:0] par2(input logic [15:0] d);
        return {^d[15:8], ^d[7:0]};
    endfunction

    function automatic logic perr_of(input logic [15:0] d, input logic [1:0] p);
        return |(par2(d) ^ p);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard when a read is due, otherwise expects quiet/held outputs.
    always @(negedge clk) begin
        if (mon_on) begin
            while (q_ab.size() > 0 && q_ab[0].due < cyc) begin
                vectors++; miscompares++;
                $display("FAIL ab_lost_read due=%0d now=%0d", q_ab[0].due, cyc);
                void'(q_ab.pop_front());
            end
            while (q_c.size() > 0 && q_c[0].due < cyc) begin
                vectors++; miscompares++;
                $display("FAIL c_lost_read due=%0d now=%0d", q_c[0].due, cyc);
                void'(q_c.pop_front());
            end
            hit_ab = (q_ab.size() > 0 && q_ab[0].due == cyc);
            if (hit_ab) begin
                mon_e = q_ab.pop_front();
                last_a = mon_e.da; last_b = mon_e.db; lp_a = mon_e.pa; lp_b = mon_e.pb;
            end
            hit_c = (q_c.size() > 0 && q_c[0].due == cyc);
            if (hit_c) begin
                mon_e = q_c.pop_front();
                last_c = mon_e.da; lp_c = mon_e.pa;
            end
            vectors++; if (rvalid_a !== hit_ab) begin miscompares++; $display("FAIL rd_valid_a cyc=%0d got %b want %b", cyc, rvalid_a, hit_ab); end
            vectors++; if (rdata_a !== last_a) begin miscompares++; $display("FAIL rd_data_a cyc=%0d got %h want %h", cyc, rdata_a, last_a); end
            vectors++; if (rvalid_b !== hit_ab) begin miscompares++; $display("FAIL rd_valid_b cyc=%0d got %b want %b", cyc, rvalid_b, hit_ab); end
            vectors++; if (rdata_b !== last_b) begin miscompares++; $display("FAIL rd_data_b cyc=%0d got %h want %h", cyc, rdata_b, last_b); end
            vectors++; if (rvalid_c !== hit_c) begin miscompares++; $display("FAIL rd_valid_c cyc=%0d got %b want %b", cyc, rvalid_c, hit_c); end
            vectors++; if (rdata_c !== last_c) begin miscompares++; $display("FAIL rd_data_c cyc=%0d got %h want %h", cyc, rdata_c, last_c); end
`ifdef RAM_PARITY_EN
            vectors++; if (perr_a !== lp_a) begin miscompares++; $display("FAIL rd_perr_a cyc=%0d got %b want %b", cyc, perr_a, lp_a); end
            vectors++; if (perr_b !== lp_b) begin miscompares++; $display("FAIL rd_perr_b cyc=%0d got %b want %b", cyc, perr_b, lp_b); end
            vectors++; if (perr_c !== lp_c) begin miscompares++; $display("FAIL rd_perr_c cyc=%0d got %b want %b", cyc, perr_c, lp_c); end
`endif
        end
    end

    // One clock of stimulus; expected read results go to the scoreboard, the model tracks writes.
    task automatic issue(input logic ini, input logic we, input logic [3:0] wa, input logic [1:0] be,
                         input logic [15:0] wd, input logic re, input logic [3:0] ra,
                         input logic inv, input bit tgt_c);
        exp_t        e;
        logic [15:0] old, mrg;
        logic [1:0]  pold, pmrg, pnew;
        init_req = ini & ~tgt_c;
        wr_en    = we & ~tgt_c;
        rd_en    = re & ~tgt_c;
        wr_en_c  = we & tgt_c;
        rd_en_c  = re & tgt_c;
        wr_addr  = wa; wr_be = be; wr_data = wd; rd_addr = ra;
`ifdef RAM_PARITY_EN
        wr_par_inv = inv;
`endif
        pnew = par2(wd) ^ {inv, inv};
        if (!tgt_c) begin
            if (clr_ab > 0) begin
                clr_ab--;
            end else begin
                if (re) begin
                    old = m[ra]; pold = pm[ra]; mrg = old; pmrg = pold;
                    for (int i = 0; i < 2; i++) begin
                        if (we && wa == ra && be[i]) begin
                            mrg[8*i +: 8] = wd[8*i +: 8];
                            pmrg[i] = pnew[i];
                        end
                    end
                    e.due = cyc + 1; e.da = old; e.pa = perr_of(old, pold);
                    e.db = mrg; e.pb = perr_of(mrg, pmrg);
                    q_ab.push_back(e);
                end
                for (int i = 0; i < 2; i++) begin
                    if (we && be[i]) begin
                        m[wa][8*i +: 8] = wd[8*i +: 8];
                        pm[wa][i] = pnew[i];
                    end
                end
                if (ini) begin
                    clr_ab = 16;
                    for (int k = 0; k < 16; k++) begin m[k] = 16'h0; pm[k] = 2'b00; end
                end
            end
        end else begin
            if (re) begin
                e.due = cyc + 1;
                if (ra < 4'd12) begin e.da = mc[ra]; e.pa = perr_of(mc[ra], pmc[ra]); end
                else begin e.da = 16'h0; e.pa = 1'b0; end
                e.db = e.da; e.pb = e.pa;
                q_c.push_back(e);
            end
            for (int i = 0; i < 2; i++) begin
                if (we && wa < 4'd12 && be[i]) begin
                    mc[wa][8*i +: 8] = wd[8*i +: 8];
                    pmc[wa][i] = pnew[i];
                end
            end
        end
        @(posedge clk); #1;
        init_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_en_c = 1'b0; rd_en_c = 1'b0;
`ifdef RAM_PARITY_EN
        wr_par_inv = 1'b0;
`endif
    endtask

    task automatic clear_models();
        for (int k = 0; k < 16; k++) begin m[k] = 16'h0; pm[k] = 2'b00; end
        for (int k = 0; k < 12; k++) begin mc[k] = 16'h0; pmc[k] = 2'b00; end
        clr_ab = 0;
    endtask

    // Holds reset for a few clocks, releases it and measures the busy window of both depths.
    task automatic reset_and_count(input string tag);
        int fa, fc;
        rst_n = 1'b0;
        last_a = 16'h0; last_b = 16'h0; last_c = 16'h0;
        lp_a = 1'b0; lp_b = 1'b0; lp_c = 1'b0;
        #1;
        vectors++; if (busy_a !== 1'b1 || busy_c !== 1'b1) begin miscompares++; $display("FAIL %s_busy_in_reset got %b/%b want 1/1", tag, busy_a, busy_c); end
        vectors++; if (rdata_a !== 16'h0 || rvalid_a !== 1'b0) begin miscompares++; $display("FAIL %s_rd_in_reset got %h/%b want 0000/0", tag, rdata_a, rvalid_a); end
`ifdef RAM_PARITY_EN
        vectors++; if (perr_a !== 1'b0) begin miscompares++; $display("FAIL %s_perr_in_reset got %b want 0", tag, perr_a); end
`endif
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL %s_busy_held got %b want 1", tag, busy_a); end
        rst_n = 1'b1;
        fa = 0; fc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (!busy_a && fa == 0) fa = k;
            if (!busy_c && fc == 0) fc = k;
        end
        vectors++; if (fa != 16) begin miscompares++; $display("FAIL %s_busy_cycles_d16 got %0d want 16", tag, fa); end
        vectors++; if (fc != 12) begin miscompares++; $display("FAIL %s_busy_cycles_d12 got %0d want 12", tag, fc); end
        clear_models();
    endtask

    task automatic test_reset();
        #1;
        mon_on = 1'b1;
        reset_and_count("por");
        for (int a = 0; a < 16; a++) issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'(a), 1'b0, 1'b0);
        vectors++; if (rvalid_a !== 1'b1 || rdata_a !== 16'h0000) begin miscompares++; $display("FAIL reset_read15 got %b/%h want 1/0000", rvalid_a, rdata_a); end
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_byte_enable();
        issue(1'b0, 1'b1, 4'd3, 2'b11, 16'hA5C3, 1'b0, 4'd0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 4'd3, 2'b10, 16'h1200, 1'b0, 4'd0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 4'd3, 2'b00, 16'hFFFF, 1'b0, 4'd0, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd3, 1'b0, 1'b0);
        vectors++; if (rvalid_a !== 1'b1 || rdata_a !== 16'h12C3) begin miscompares++; $display("FAIL byte_enable got %b/%h want 1/12c3", rvalid_a, rdata_a); end
        issue(1'b0, 1'b1, 4'd4, 2'b11, 16'h7777, 1'b1, 4'd3, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd4, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        vectors++; if (rvalid_a !== 1'b0 || rdata_a !== 16'h7777) begin miscompares++; $display("FAIL read_hold got %b/%h want 0/7777", rvalid_a, rdata_a); end
    endtask

    task automatic test_rdw();
        issue(1'b0, 1'b1, 4'd5, 2'b11, 16'h1111, 1'b0, 4'd0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 4'd5, 2'b01, 16'hBEEF, 1'b1, 4'd5, 1'b0, 1'b0);
        vectors++; if (rdata_a !== 16'h1111) begin miscompares++; $display("FAIL rdw_old got %h want 1111", rdata_a); end
        vectors++; if (rdata_b !== 16'h11EF) begin miscompares++; $display("FAIL rdw_new got %h want 11ef", rdata_b); end
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd5, 1'b0, 1'b0);
        vectors++; if (rdata_a !== 16'h11EF || rdata_b !== 16'h11EF) begin miscompares++; $display("FAIL rdw_after got %h/%h want 11ef/11ef", rdata_a, rdata_b); end
        issue(1'b0, 1'b1, 4'd6, 2'b11, 16'h5A5A, 1'b1, 4'd7, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 4'd7, 2'b11, 16'hC0DE, 1'b1, 4'd6, 1'b0, 1'b0);
    endtask

    task automatic test_clear();
        int n;
        for (int a = 0; a < 16; a++) issue(1'b0, 1'b1, 4'(a), 2'b11, 16'(a * 257 + 1), 1'b0, 4'd0, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd9, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd15, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy_a) break;
            n++;
            issue(k % 4 == 1, 1'b1, 4'(k), 2'b11, 16'hFFFF, 1'b1, 4'(k), 1'b0, 1'b0);
            vectors++; if (rvalid_a !== 1'b0) begin miscompares++; $display("FAIL clear_rd_valid k=%0d got %b want 0", k, rvalid_a); end
        end
        vectors++; if (n != 16) begin miscompares++; $display("FAIL clear_busy_cycles got %0d want 16", n); end
        for (int a = 0; a < 16; a++) issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'(a), 1'b0, 1'b0);
    endtask

    task automatic test_out_of_range();
        for (int a = 0; a < 12; a++) issue(1'b0, 1'b1, 4'(a), 2'b11, 16'(16'h0A00 + a), 1'b0, 4'd0, 1'b0, 1'b1);
        issue(1'b0, 1'b1, 4'd13, 2'b11, 16'hFFFF, 1'b0, 4'd0, 1'b0, 1'b1);
        issue(1'b0, 1'b1, 4'd12, 2'b11, 16'hFFFF, 1'b0, 4'd0, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd11, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd13, 1'b0, 1'b1);
        vectors++; if (rvalid_c !== 1'b1 || rdata_c !== 16'h0000) begin miscompares++; $display("FAIL oor_read got %b/%h want 1/0000", rvalid_c, rdata_c); end
        for (int a = 0; a < 12; a++) issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'(a), 1'b0, 1'b1);
        vectors++; if (rdata_c !== 16'h0A0B) begin miscompares++; $display("FAIL oor_neighbour got %h want 0a0b", rdata_c); end
    endtask

`ifdef RAM_PARITY_EN
    task automatic test_parity();
        issue(1'b0, 1'b1, 4'd2, 2'b01, 16'h00FF, 1'b0, 4'd0, 1'b1, 1'b0);
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd2, 1'b0, 1'b0);
        vectors++; if (perr_a !== 1'b1) begin miscompares++; $display("FAIL perr_injected got %b want 1", perr_a); end
        issue(1'b0, 1'b1, 4'd2, 2'b01, 16'h00FF, 1'b0, 4'd0, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd2, 1'b0, 1'b0);
        vectors++; if (perr_a !== 1'b0) begin miscompares++; $display("FAIL perr_clean got %b want 0", perr_a); end
        issue(1'b0, 1'b1, 4'd2, 2'b01, 16'h00FF, 1'b0, 4'd0, 1'b1, 1'b0);
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd2, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        reset_and_count("midclr");
        issue(1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd2, 1'b0, 1'b0);
        vectors++; if (perr_a !== 1'b0 || rdata_a !== 16'h0000) begin miscompares++; $display("FAIL perr_after_clear got %b/%h want 0/0000", perr_a, rdata_a); end
    endtask
`endif

    initial begin
        test_reset();
        test_byte_enable();
        test_rdw();
        test_clear();
        test_out_of_range();
`ifdef RAM_PARITY_EN
        test_parity();
`endif
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (q_ab.size() != 0 || q_c.size() != 0) begin
            miscompares++;
            $display("FAIL pending_reads got %0d/%0d want 0/0", q_ab.size(), q_c.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
